// File: rtl/gf2n_add_acc.sv
// Lane-wise GF(2^W) adder with a packet accumulate mode: beats are XOR-folded
// until in_last, then the folded lanes and a saturating beat count are presented.
module gf2n_add_acc #(
  parameter int W     = 2,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic               in_last,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic [7:0]         out_cnt
);

  localparam int DW = LANES * W;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_e;

  // Field addition carries nothing between bits, so whole-vector XOR is lane-wise.
  function automatic logic [DW-1:0] gf_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return x ^ y;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'd255) ? 8'd255 : c + 8'd1;
  endfunction

  state_e          state_q, state_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [7:0]      out_cnt_q, out_cnt_d;
  logic            accept_s;
  logic [DW-1:0]   beat_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign beat_s    = gf_add(a, b);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;

  // Next-state: drain on transfer, then a result-producing beat may reload in the same cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s) begin
      case (state_q)
        S_IDLE: begin
          if (mode && !in_last) begin
            acc_d   = beat_s;
            cnt_d   = 8'd1;
            state_d = S_ACCUM;
          end else begin
            out_data_d  = beat_s;
            out_cnt_d   = 8'd1;
            out_valid_d = 1'b1;
          end
        end
        S_ACCUM: begin
          if (in_last) begin
            out_data_d  = gf_add(acc_q, beat_s);
            out_cnt_d   = sat_inc(cnt_q);
            out_valid_d = 1'b1;
            acc_d       = {DW{1'b0}};
            cnt_d       = 8'd0;
            state_d     = S_IDLE;
          end else begin
            acc_d = gf_add(acc_q, beat_s);
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= {DW{1'b0}};
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
      out_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_gf2n_add_acc.sv
// Bench for gf2n_add_acc (W=2, LANES=4): directed scenarios plus random traffic,
// checked against a packet-level model that folds queued beats at in_last.
module tb_gf2n_add_acc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic       in_last;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_cnt;

  int checks = 0;
  int errors = 0;

  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_cnt;
  logic       m_open;
  logic [7:0] pkt_q[$];
  logic       seen_ready;

  gf2n_add_acc #(.W(2), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in_last(in_last), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet-level reference: a packet is the list of beat sums; its result is their XOR.
  task automatic model_step(input logic v, input logic m, input logic l,
                            input logic [7:0] av, input logic [7:0] bv,
                            input logic ordy, input logic rdy);
    logic [7:0] x;
    if (m_valid && ordy) m_valid = 1'b0;
    if (v && rdy) begin
      if (!m_open && m && !l) begin
        m_open = 1'b1;
        pkt_q.delete();
        pkt_q.push_back(av ^ bv);
      end else if (!m_open) begin
        m_valid = 1'b1;
        m_data  = av ^ bv;
        m_cnt   = 8'd1;
      end else begin
        pkt_q.push_back(av ^ bv);
        if (l) begin
          x = 8'h00;
          foreach (pkt_q[i]) x = x ^ pkt_q[i];
          m_data  = x;
          m_cnt   = (pkt_q.size() > 255) ? 8'd255 : 8'(pkt_q.size());
          m_valid = 1'b1;
          m_open  = 1'b0;
          pkt_q.delete();
        end
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_cnt   = 8'h00;
    m_open  = 1'b0;
    pkt_q.delete();
  endtask

  // One clock: drive after negedge, check in_ready, clock, check outputs at next negedge.
  task automatic cycle(input logic v, input logic m, input logic l,
                       input logic [7:0] av, input logic [7:0] bv, input logic ordy);
    logic rdy;
    in_valid = v; mode = m; in_last = l; a = av; b = bv; out_ready = ordy;
    rdy = !m_valid || ordy;
    #1;
    seen_ready = in_ready;
    checks++;
    if (in_ready !== rdy) begin
      errors++;
      $display("FAIL in_ready: got %b exp %b at %0t", in_ready, rdy, $time);
    end
    @(posedge clk);
    model_step(v, m, l, av, bv, ordy, rdy);
    @(negedge clk);
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid: got %b exp %b at %0t", out_valid, m_valid, $time);
    end
    if (m_valid) begin
      checks++;
      if (out_data !== m_data || out_cnt !== m_cnt) begin
        errors++;
        $display("FAIL result: got data %h cnt %0d exp data %h cnt %0d at %0t",
                 out_data, out_cnt, m_data, m_cnt, $time);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ordy);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_cnt !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got valid %b data %h cnt %0d rdy %b exp 0 00 0 1",
               tag, out_valid, out_data, out_cnt, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; in_last = 1'b0;
    a = 8'h00; b = 8'h00; out_ready = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
  endtask

  task automatic test_add();
    idle(1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'hE4, 8'h1B, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || out_cnt !== 8'd1) begin
      errors++;
      $display("FAIL add_e4_1b: got %b %h %0d exp 1 ff 1", out_valid, out_data, out_cnt);
    end
    cycle(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
    checks++;
    if (out_data !== 8'h99 || out_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_beat_pkt: got %h %0d exp 99 1", out_data, out_cnt);
    end
  endtask

  task automatic test_accum();
    idle(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'h04, 8'h08, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL accum_early: got out_valid %b exp 0", out_valid);
    end
    cycle(1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3F || out_cnt !== 8'd3) begin
      errors++;
      $display("FAIL accum_3beat: got %b %h %0d exp 1 3f 3", out_valid, out_data, out_cnt);
    end
  endtask

  task automatic test_backpressure();
    idle(1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h5A, 8'h0F, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 1'b0);
    checks++;
    if (seen_ready !== 1'b0 || out_data !== 8'h55) begin
      errors++;
      $display("FAIL bp_hold: got rdy %b data %h exp 0 55", seen_ready, out_data);
    end
    cycle(1'b1, 1'b1, 1'b0, 8'h77, 8'h77, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h33 || out_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_no_bubble: got %b %h %0d exp 1 33 1", out_valid, out_data, out_cnt);
    end
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    idle(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'hC0, 8'h01, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'h0C, 8'h30, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 8'h03, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h03 || out_cnt !== 8'd1) begin
      errors++;
      $display("FAIL after_reset_pkt: got %b %h %0d exp 1 03 1", out_valid, out_data, out_cnt);
    end
  endtask

  task automatic test_saturation();
    idle(1'b1);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b1, (i == 299) ? 1'b1 : 1'b0, 8'h01, 8'h00, 1'b1);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || out_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_300: got %b %h %0d exp 1 00 255", out_valid, out_data, out_cnt);
    end
  endtask

  task automatic test_mode_toggle();
    idle(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL toggle_early: got out_valid %b exp 0", out_valid);
    end
    cycle(1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_cnt !== 8'd4) begin
      errors++;
      $display("FAIL toggle_pkt: got %b %h %0d exp 1 c3 4", out_valid, out_data, out_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 9) < 7));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_accum();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_mode_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf2n_add_acc.md
GF2N_ADD_ACC -- requirements
Module: gf2n_add_acc

Interface
REQ-001 The block SHALL have parameter W, default 2, giving the GF(2^W) element width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of independent elements processed per beat.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input beat is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = pairwise add, 1 = accumulate packet.
REQ-008 The block SHALL have port in_last, input, 1 bit: last beat of an accumulate packet; ignored in add mode.
REQ-009 The block SHALL have port a, input, LANES*W bits: operand A; lane i is a[i*W +: W].
REQ-010 The block SHALL have port b, input, LANES*W bits: operand B, with the same lane packing as a.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is held.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the sink accepts the result.
REQ-013 The block SHALL have port out_data, output, LANES*W bits: result lanes.
REQ-014 The block SHALL have port out_cnt, output, 8 bits: number of beats folded into out_data.

Function
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1; a result SHALL be transferred when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally; there is no dependency on in_valid.
REQ-017 GF(2^W) addition SHALL be lane-wise bitwise XOR, with no carries and no interaction between lanes.
REQ-018 The FSM SHALL have two states: IDLE (no packet open) and ACCUM (packet open).
REQ-019 The packet mode SHALL be latched from the mode input on the first accepted beat in IDLE; mode SHALL be ignored while in ACCUM.
REQ-020 In IDLE with mode=0, an accepted beat SHALL load out_data = a^b and out_cnt = 1, and set out_valid the next cycle; the FSM stays in IDLE.
REQ-021 In IDLE with mode=1 and in_last=0, an accepted beat SHALL load acc = a^b and cnt = 1, and move the FSM to ACCUM; no output is produced.
REQ-022 In IDLE with mode=1 and in_last=1, an accepted beat SHALL behave as REQ-020: a single-beat packet.
REQ-023 In ACCUM with in_last=0, an accepted beat SHALL update acc ^= a^b and cnt += 1, saturating at 255.
REQ-024 In ACCUM with in_last=1, an accepted beat SHALL load out_data = acc^a^b and out_cnt = sat(cnt+1), clear acc to 0 and cnt to 0, set out_valid, and move to IDLE.
REQ-025 Latency SHALL be 1 cycle from the accepted result-producing beat to out_valid=1.
REQ-026 out_data and out_cnt SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 A transfer and a new result load in the same cycle SHALL leave out_valid=1 with the new data, with no bubble.
REQ-028 A transfer with no new result in the same cycle SHALL clear out_valid.
REQ-029 A non-last accumulate beat SHALL be accepted only under REQ-016; it SHALL NOT alter out_data or out_valid.
REQ-030 cnt SHALL saturate at 255 and SHALL NOT wrap; acc SHALL keep folding beyond saturation.
REQ-031 Throughput SHALL be one beat per cycle when out_ready=1.

Reset
REQ-032 While rst_n=0, the block SHALL force: FSM=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_cnt=0; in_ready then evaluates to 1.
REQ-033 Reset asserted mid-packet or while a result is held SHALL discard the packet and result; the first beat after reset release starts a new packet.

Verification (W=2, LANES=4)
REQ-034 The bench SHALL cover: add, mode=0, a=8'hE4, b=8'h1B, out_ready=1 -> next cycle out_valid=1, out_data=8'hFF, out_cnt=1.
REQ-035 The bench SHALL cover: accumulate, mode=1, beats (01,02), (04,08), (10,20 last) -> out_data=8'h3F, out_cnt=3 one cycle after the last beat, and no output earlier.
REQ-036 The bench SHALL cover: backpressure, out_ready=0 with a result held -> in_ready=0 and out_data stable; then out_ready=1 plus a new add beat in the same cycle -> next result held with no bubble.
REQ-037 The bench SHALL cover: rst_n pulsed low after 2 accumulate beats -> out_valid=0, then a packet (03,00 last) -> out_data=8'h03, out_cnt=1.
REQ-038 The bench SHALL cover: 300-beat accumulate packet of identical beats (a=01, b=00) -> out_cnt=255, out_data=8'h00 (even count).
REQ-039 The bench SHALL cover: mode toggled to 0 mid-packet -> still accumulates until in_last.
